// File: rtl/picorv32_mem_arb.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory bus, one transaction in flight.
// Optional round-robin priority is enabled by defining MEM_ARB_RR_EN; default build uses fixed PRIO_DATA.
module picorv32_mem_arb #(
    parameter logic PRIO_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,

    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,

    output logic        bus_valid,
    output logic        bus_instr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_instr_q, bus_instr_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;

    logic        prio_data;
    logic        grant_d;
    logic        grant_i;

`ifdef MEM_ARB_RR_EN
    logic        prio_q, prio_d;
    logic        done;

    // Priority flips after every completed transaction so neither port can starve.
    assign done      = (state_q != IDLE) && bus_ready;
    assign prio_d    = done ? ~prio_q : prio_q;
    assign prio_data = prio_q;
`else
    assign prio_data = PRIO_DATA;
`endif

    assign grant_d = mem_valid && (!instr_valid || prio_data);
    assign grant_i = instr_valid && !grant_d;

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_instr_d = bus_instr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    bus_valid_d = 1'b1;
                    bus_instr_d = mem_instr;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_wstrb_d = mem_wstrb;
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    bus_valid_d = 1'b1;
                    bus_instr_d = 1'b1;
                    bus_addr_d  = instr_addr;
                    bus_wdata_d = 32'h0;
                    bus_wstrb_d = 4'h0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Completion is driven by the bus alone, even if the requester already dropped valid.
                if (bus_ready) begin
                    state_d     = IDLE;
                    bus_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            bus_instr_q <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'h0;
`ifdef MEM_ARB_RR_EN
            prio_q      <= PRIO_DATA;
`endif
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_instr_q <= bus_instr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
`ifdef MEM_ARB_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_instr = bus_instr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

    // Ready pulses are masked during reset so a stray bus_ready cannot complete an aborted transfer.
    assign instr_ready = (state_q == BUSY_I) && bus_ready && !reset;
    assign mem_ready   = (state_q == BUSY_D) && bus_ready && !reset;
    assign instr_rdata = instr_ready ? bus_rdata : 32'h0;
    assign mem_rdata   = mem_ready ? bus_rdata : 32'h0;

endmodule

// File: tb/tb_picorv32_mem_arb.sv
// Self-checking bench for picorv32_mem_arb: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbiter.
module tb_picorv32_mem_arb;

    localparam logic PRIO = 1'b1;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        bus_valid;
    logic        bus_instr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    picorv32_mem_arb #(.PRIO_DATA(PRIO)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_addr  (instr_addr),
        .instr_rdata (instr_rdata),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .bus_valid   (bus_valid),
        .bus_instr   (bus_instr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } txn_t;

    // Model: at most one outstanding transaction, plus which port currently wins a tie.
    txn_t q[$];
    logic m_prio_data;
    logic exp_ir;
    logic exp_mr;
    logic pend_i;
    logic pend_d;
    int   total;
    int   passed;
    int   failed;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs for the current inputs, then advance the model at the edge.
    task automatic step();
        txn_t t;
        #1;
        exp_ir = !reset && (q.size() > 0) && !q[0].is_data && bus_ready;
        exp_mr = !reset && (q.size() > 0) && q[0].is_data && bus_ready;
        checkOutput("bus_valid", {31'h0, bus_valid}, {31'h0, q.size() > 0});
        if (q.size() > 0) begin
            checkOutput("bus_instr", {31'h0, bus_instr}, {31'h0, q[0].instr});
            checkOutput("bus_addr", bus_addr, q[0].addr);
            checkOutput("bus_wdata", bus_wdata, q[0].wdata);
            checkOutput("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, q[0].wstrb});
        end
        checkOutput("instr_ready", {31'h0, instr_ready}, {31'h0, exp_ir});
        checkOutput("mem_ready", {31'h0, mem_ready}, {31'h0, exp_mr});
        checkOutput("instr_rdata", instr_rdata, exp_ir ? bus_rdata : 32'h0);
        checkOutput("mem_rdata", mem_rdata, exp_mr ? bus_rdata : 32'h0);
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_prio_data = PRIO;
        end else if (q.size() > 0) begin
            if (bus_ready) begin
                q.delete(0);
`ifdef MEM_ARB_RR_EN
                m_prio_data = !m_prio_data;
`endif
            end
        end else if (mem_valid && (!instr_valid || m_prio_data)) begin
            t.is_data = 1'b1;
            t.addr    = mem_addr;
            t.wdata   = mem_wdata;
            t.wstrb   = mem_wstrb;
            t.instr   = mem_instr;
            q.push_back(t);
        end else if (instr_valid) begin
            t.is_data = 1'b0;
            t.addr    = instr_addr;
            t.wdata   = 32'h0;
            t.wstrb   = 4'h0;
            t.instr   = 1'b1;
            q.push_back(t);
        end
        @(negedge clk);
    endtask

    // Random requesters that hold valid and fields stable until their ready pulse.
    task automatic applyStimulus();
        reset = ($urandom_range(0, 99) == 0);
        if (!pend_i && $urandom_range(0, 2) == 0) begin
            pend_i     = 1'b1;
            instr_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!pend_d && $urandom_range(0, 2) == 0) begin
            pend_d    = 1'b1;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom_range(0, 15));
            mem_instr = 1'($urandom_range(0, 1));
        end
        instr_valid = pend_i;
        mem_valid   = pend_d;
        bus_ready   = 1'($urandom_range(0, 1));
        bus_rdata   = $urandom;
    endtask

    logic exp_order [4];

    initial begin
        total = 0; passed = 0; failed = 0;
        pend_i = 1'b0; pend_d = 1'b0;
        m_prio_data = PRIO;
        reset = 1'b1;
        instr_valid = 1'b0; instr_addr = 32'h0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        step();
        checkOutput("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        checkOutput("rst_bus_instr", {31'h0, bus_instr}, 32'h0);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
        checkOutput("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        step();
        reset = 1'b0;

        // Single instruction fetch, bus answers on the second busy cycle.
        instr_valid = 1'b1; instr_addr = 32'h0000_0100;
        step();
        checkOutput("fetch_bus_valid", {31'h0, bus_valid}, 32'h1);
        checkOutput("fetch_bus_instr", {31'h0, bus_instr}, 32'h1);
        checkOutput("fetch_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        step();
        bus_ready = 1'b1; bus_rdata = 32'h0000_0013;
        #1;
        checkOutput("fetch_instr_ready", {31'h0, instr_ready}, 32'h1);
        checkOutput("fetch_instr_rdata", instr_rdata, 32'h0000_0013);
        step();
        instr_valid = 1'b0; bus_ready = 1'b0;
        step();

        // Single data write.
        mem_valid = 1'b1; mem_addr = 32'h0000_2000; mem_wstrb = 4'hF; mem_wdata = 32'hDEAD_BEEF; mem_instr = 1'b0;
        step();
        checkOutput("write_bus_addr", bus_addr, 32'h0000_2000);
        checkOutput("write_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        checkOutput("write_bus_wstrb", {28'h0, bus_wstrb}, 32'hF);
        checkOutput("write_bus_instr", {31'h0, bus_instr}, 32'h0);
        step();
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        #1;
        checkOutput("write_mem_ready", {31'h0, mem_ready}, 32'h1);
        checkOutput("write_instr_ready", {31'h0, instr_ready}, 32'h0);
        step();
        mem_valid = 1'b0; bus_ready = 1'b0;
        step();

        // Both ports requesting continuously: grant order over four transactions.
`ifdef MEM_ARB_RR_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
`endif
        instr_valid = 1'b1; instr_addr = 32'h0000_0400;
        mem_valid = 1'b1; mem_addr = 32'h0000_3000; mem_wstrb = 4'h0; mem_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            bus_ready = 1'b0;
            step();
            checkOutput("order_bus_instr", {31'h0, bus_instr}, {31'h0, exp_order[k]});
            bus_ready = 1'b1; bus_rdata = $urandom;
            step();
        end
        mem_valid = 1'b0; bus_ready = 1'b0;
        step();
        checkOutput("order_instr_last", {31'h0, bus_instr}, 32'h1);
        bus_ready = 1'b1;
        step();
        instr_valid = 1'b0; bus_ready = 1'b0;
        step();

        // Reset while a data transaction is outstanding, with bus_ready high.
        mem_valid = 1'b1; mem_addr = 32'h0000_5000; mem_wstrb = 4'h3; mem_wdata = 32'hCAFE_F00D;
        step();
        reset = 1'b1; bus_ready = 1'b1;
        #1;
        checkOutput("rstbusy_mem_ready", {31'h0, mem_ready}, 32'h0);
        step();
        reset = 1'b0; bus_ready = 1'b0; mem_valid = 1'b0;
        checkOutput("rstbusy_bus_valid", {31'h0, bus_valid}, 32'h0);
        step();

        // Granted fetch abandoned by the core before the bus answers.
        instr_valid = 1'b1; instr_addr = 32'h0000_0800;
        step();
        instr_valid = 1'b0;
        step();
        step();
        checkOutput("drop_bus_valid", {31'h0, bus_valid}, 32'h1);
        bus_ready = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        #1;
        checkOutput("drop_instr_ready", {31'h0, instr_ready}, 32'h1);
        step();
        bus_ready = 1'b0;
        checkOutput("drop_bus_idle", {31'h0, bus_valid}, 32'h0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus();
            step();
            checkOutput("ready_exclusive", {31'h0, instr_ready & mem_ready}, 32'h0);
            if (exp_ir) pend_i = 1'b0;
            if (exp_mr) pend_d = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
